// File: rtl/dice_roll_ctrl_if.sv
// Button-in / face-out bundle between the board button, the dice sequencer and the pip decoder.
interface dice_roll_ctrl_if;
    logic       btn;
    logic [2:0] num;
    logic [2:0] result;
    logic       rolling;
    logic       done;

    modport master (output btn, input num, result, rolling, done);
    modport slave  (input btn, output num, result, rolling, done);
endinterface

// File: rtl/dice_roll_ctrl.sv
// Dice roll sequencer: fast cycling while the button is held, decelerating stop, hold of the face.
// Optional feature macro DICE_BLINK_EN: blinks the held face on NUM during HOLD.
module dice_roll_ctrl #(
`ifdef DICE_BLINK_EN
    parameter int BLINK_TICKS = 2,
`endif
    parameter int TICK_DIV    = 24,
    parameter int SLOW_STEPS  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    dice_roll_ctrl_if.slave  bus
);

    localparam int PRE_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, ROLL, SLOW, HOLD} state_t;

    state_t     state_q, state_d;
    logic       btn_meta, btn_s, btn_s_q;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0] step_q, step_d;
    logic [3:0] wait_q, wait_d;
    logic [2:0] num_q, num_d;
    logic [2:0] result_q, result_d;
    logic       rolling_q, rolling_d;
    logic       done_q, done_d;
    logic       tick;
    logic       rise;

`ifdef DICE_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
`endif

    function automatic logic [2:0] next_face(input logic [2:0] n);
        return (n == 3'd6) ? 3'd1 : n + 3'd1;
    endfunction

    assign tick = (pre_q == PRE_W'(TICK_DIV - 1));
    assign rise = btn_s & ~btn_s_q;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        result_d  = result_q;
        rolling_d = rolling_q;
        done_d    = 1'b0;
        step_d    = step_q;
        wait_d    = wait_q;
        pre_d     = tick ? '0 : pre_q + 1'b1;
`ifdef DICE_BLINK_EN
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d   = ROLL;
                    num_d     = 3'd1;
                    rolling_d = 1'b1;
                    pre_d     = '0;
                end
            end
            ROLL: begin
                if (!btn_s) begin
                    state_d = SLOW;
                    step_d  = 4'd1;
                    wait_d  = '0;
                    pre_d   = '0;
                end else if (tick) begin
                    num_d = next_face(num_q);
                end
            end
            SLOW: begin
                // Step k waits k ticks; the button is deliberately not looked at here.
                if (tick) begin
                    if (wait_q + 4'd1 == step_q) begin
                        num_d  = next_face(num_q);
                        wait_d = '0;
                        step_d = step_q + 4'd1;
                        if (step_q == 4'(SLOW_STEPS)) begin
                            state_d   = HOLD;
                            result_d  = next_face(num_q);
                            done_d    = 1'b1;
                            rolling_d = 1'b0;
                            step_d    = '0;
                            pre_d     = '0;
`ifdef DICE_BLINK_EN
                            blink_cnt_d = '0;
                            blink_on_d  = 1'b1;
`endif
                        end
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (rise) begin
                    state_d   = ROLL;
                    num_d     = result_q;
                    result_d  = '0;
                    rolling_d = 1'b1;
                    pre_d     = '0;
                end
`ifdef DICE_BLINK_EN
                else if (tick) begin
                    if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
                        blink_cnt_d = '0;
                        blink_on_d  = ~blink_on_q;
                        num_d       = blink_on_q ? 3'd0 : result_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            btn_meta  <= 1'b0;
            btn_s     <= 1'b0;
            btn_s_q   <= 1'b0;
            pre_q     <= '0;
            step_q    <= '0;
            wait_q    <= '0;
            num_q     <= '0;
            result_q  <= '0;
            rolling_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef DICE_BLINK_EN
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
`endif
        end else begin
            btn_meta  <= bus.btn;
            btn_s     <= btn_meta;
            btn_s_q   <= btn_s;
            state_q   <= state_d;
            pre_q     <= pre_d;
            step_q    <= step_d;
            wait_q    <= wait_d;
            num_q     <= num_d;
            result_q  <= result_d;
            rolling_q <= rolling_d;
            done_q    <= done_d;
`ifdef DICE_BLINK_EN
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
`endif
        end
    end

    assign bus.num     = num_q;
    assign bus.result  = result_q;
    assign bus.rolling = rolling_q;
    assign bus.done    = done_q;

endmodule
